fb_arbiter: RTL and testbench

FB_ARBITER -- requirements
Module: fb_arbiter

---
 rtl/fb_pkg.sv | 13 +
 rtl/fb_skid.sv | 59 +++++
 rtl/fb_arbiter.sv | 152 +++++++++++++++
 tb/tb_fb_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and default constants for the frame-buffer arbiter
package fb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VGA  = 2'd1,
        HOST = 2'd2
    } fb_state_e;

    localparam int unsigned FB_WORDS_DEF  = 307200;
    localparam int unsigned VGA_BURST_DEF = 8;
    localparam int unsigned ADDR_W_DEF    = 19;
    localparam int unsigned PIX_W         = 16;
endpackage

// File: rtl/fb_skid.sv
// rtl/fb_skid.sv - 2-entry FIFO-order skid buffer between memory read data and the pixel FIFO
module fb_skid
    import fb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [PIX_W-1:0] push_data,
    input  logic             pop,
    output logic [PIX_W-1:0] data,
    output logic [1:0]       count
);
    logic [PIX_W-1:0] r_head;
    logic [PIX_W-1:0] r_tail;
    logic [1:0]       r_count;
    logic             w_pop;

    // A pop of an empty buffer is ignored so push+pop always means a real hand-over.
    assign w_pop = pop && (r_count != 2'd0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= push_data;
                    end else begin
                        r_tail <= push_data;
                    end
                    if (r_count != 2'd2) begin
                        r_count <= r_count + 2'd1;
                    end
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_head <= r_tail;
                        r_tail <= push_data;
                    end else begin
                        r_head <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data  = r_head;
    assign count = r_count;
endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port memory arbiter between VGA pixel fetch and host accesses
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned FB_BASE   = 0,
    parameter int unsigned FB_WORDS  = FB_WORDS_DEF,
    parameter int unsigned VGA_BURST = VGA_BURST_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vtrigger,
    input  logic              fifo_full,
    output logic [15:0]       fifo_data,
    output logic              fifo_write,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [15:0]       host_wdata,
    output logic              host_ack,
    output logic [15:0]       host_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata,
    output logic              frame_done
);
    localparam int unsigned       CNT_W     = $clog2(FB_WORDS + 1);
    localparam int unsigned       RUN_W     = $clog2(VGA_BURST + 1);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(FB_BASE);
    localparam logic [CNT_W-1:0]  WORDS_CNT = CNT_W'(FB_WORDS);
    localparam logic [RUN_W-1:0]  BURST_CNT = RUN_W'(VGA_BURST);

    fb_state_e         r_state;
    fb_state_e         w_next_state;
    logic [ADDR_W-1:0] r_fptr;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_written;
    logic [RUN_W-1:0]  r_run;
    logic              r_rd_pend;
    logic              r_host_pend;
    logic              r_frame_done;
    logic              r_mem_cs;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;

    logic [1:0]        w_skid_count;
    logic [15:0]       w_skid_data;
    logic [2:0]        w_outstanding;
    logic              w_vga_elig;
    logic              w_host_elig;
    logic              w_grant_vga;
    logic              w_grant_host;
    logic              w_fifo_write;

    // Outstanding = skid entries + read on the bus now + read whose data is on mem_rdata now.
    always_comb begin
        w_outstanding = {1'b0, w_skid_count} + {2'b00, (r_state == VGA)} + {2'b00, r_rd_pend};
        w_vga_elig    = (r_issued != WORDS_CNT) && (w_outstanding < 3'd2) && !vtrigger;
        w_host_elig   = host_req && (r_state != HOST);
        w_grant_host  = w_host_elig && (!w_vga_elig || (r_run == BURST_CNT));
        w_grant_vga   = w_vga_elig && !w_grant_host;
        w_next_state  = IDLE;
        if (w_grant_host) begin
            w_next_state = HOST;
        end else if (w_grant_vga) begin
            w_next_state = VGA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_mem_cs     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fptr       <= BASE_ADDR;
            r_issued     <= WORDS_CNT;
            r_written    <= '0;
            r_run        <= '0;
            r_rd_pend    <= 1'b0;
            r_host_pend  <= 1'b0;
            r_frame_done <= 1'b1;
        end else begin
            r_state     <= w_next_state;
            r_mem_cs    <= w_grant_vga || w_grant_host;
            r_mem_we    <= w_grant_host && host_we;
            r_host_pend <= (r_state == HOST);
            // A read on the bus during vtrigger belongs to the old frame; its data is dropped.
            r_rd_pend   <= (r_state == VGA) && !vtrigger;

            if (w_grant_host) begin
                r_mem_addr  <= host_addr;
                r_mem_wdata <= host_wdata;
            end else if (w_grant_vga) begin
                r_mem_addr <= r_fptr;
            end

            if (w_grant_vga) begin
                if (r_run != BURST_CNT) begin
                    r_run <= r_run + RUN_W'(1);
                end
            end else begin
                r_run <= '0;
            end

            if (vtrigger) begin
                r_fptr       <= BASE_ADDR;
                r_issued     <= '0;
                r_written    <= '0;
                r_frame_done <= 1'b0;
            end else begin
                if (w_grant_vga) begin
                    r_fptr   <= r_fptr + ADDR_W'(1);
                    r_issued <= r_issued + CNT_W'(1);
                end
                if (w_fifo_write) begin
                    r_written <= r_written + CNT_W'(1);
                    if (r_written == WORDS_CNT - CNT_W'(1)) begin
                        r_frame_done <= 1'b1;
                    end
                end
            end
        end
    end

    assign w_fifo_write = (w_skid_count != 2'd0) && !fifo_full && !rst;

    fb_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .flush     (vtrigger),
        .push      (r_rd_pend),
        .push_data (mem_rdata),
        .pop       (w_fifo_write),
        .data      (w_skid_data),
        .count     (w_skid_count)
    );

    assign fifo_write = w_fifo_write;
    assign fifo_data  = w_skid_data;
    assign host_ack   = r_host_pend && !rst;
    assign host_rdata = host_ack ? mem_rdata : 16'h0000;
    assign mem_cs     = r_mem_cs;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - directed self-checking bench for fb_arbiter
module tb_fb_arbiter;
    localparam int AW    = 12;
    localparam int BASE  = 'h40;
    localparam int WORDS = 16;
    localparam int BURST = 8;

    logic          clk = 1'b0;
    logic          rst, vtrigger, fifo_full, host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [15:0]   host_wdata;
    logic [15:0]   fifo_data, host_rdata, mem_wdata;
    logic          fifo_write, host_ack, mem_cs, mem_we, frame_done;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_rdata = 16'h0000;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    fb_arbiter #(
        .ADDR_W(AW), .FB_BASE(BASE), .FB_WORDS(WORDS), .VGA_BURST(BURST)
    ) dut (
        .clk(clk), .rst(rst), .vtrigger(vtrigger), .fifo_full(fifo_full),
        .fifo_data(fifo_data), .fifo_write(fifo_write),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(int a);
        return 16'hA000 | 16'(a);
    endfunction

    bit [15:0] mem_w [0:4095];
    bit        mem_wf [0:4095];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_cs && mem_we) begin
            mem_w[mem_addr]  <= mem_wdata;
            mem_wf[mem_addr] <= 1'b1;
        end
        if (mem_cs && !mem_we)
            mem_rdata <= mem_wf[mem_addr] ? mem_w[mem_addr] : pat(int'(mem_addr));
    end

    int rd_q[$];
    int rd_cyc[$];
    logic [15:0] pix_q[$];
    int pix_cyc[$];
    int n_rd, n_wr, n_wr_full, n_host_wr, n_cs, n_ack, max_out, done_cyc;
    logic prev_done = 1'b1;

    always @(negedge clk) begin
        if (mem_cs && !mem_we && int'(mem_addr) >= BASE && int'(mem_addr) < BASE + WORDS) begin
            rd_q.push_back(int'(mem_addr));
            rd_cyc.push_back(cyc);
            n_rd++;
        end
        if (mem_cs && mem_we) n_host_wr++;
        if (mem_cs) n_cs++;
        if (host_ack) n_ack++;
        if (fifo_write) begin
            pix_q.push_back(fifo_data);
            pix_cyc.push_back(cyc);
            n_wr++;
            if (fifo_full) n_wr_full++;
        end
        if (n_rd - n_wr > max_out) max_out = n_rd - n_wr;
        if (frame_done && !prev_done) done_cyc = cyc;
        prev_done = frame_done;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_full(input logic v);
        @(posedge clk);
        #1;
        fifo_full = v;
    endtask

    task automatic clear_mon();
        rd_q.delete(); rd_cyc.delete(); pix_q.delete(); pix_cyc.delete();
        n_rd = 0; n_wr = 0; n_wr_full = 0; n_host_wr = 0; n_cs = 0; n_ack = 0;
        max_out = 0; done_cyc = -1;
    endtask

    task automatic pulse_vtrig();
        vtrigger = 1'b1;
        clear_mon();
        step();
        vtrigger = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step();
            if (frame_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        int bad_rd = 0;
        int bad_px = 0;
        foreach (rd_q[k]) if (rd_q[k] != BASE + k) bad_rd++;
        foreach (pix_q[k]) if (pix_q[k] !== pat(BASE + k)) bad_px++;
        checks++;
        if (rd_q.size() != WORDS || bad_rd != 0) begin
            errors++;
            $display("FAIL %s_read_seq: got %0d reads (%0d out of order) want %0d in order", tag, rd_q.size(), bad_rd, WORDS);
        end
        checks++;
        if (pix_q.size() != WORDS || bad_px != 0) begin
            errors++;
            $display("FAIL %s_pixels: got %0d pixels (%0d wrong) want %0d matching pattern", tag, pix_q.size(), bad_px, WORDS);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; vtrigger = 1'b0; fifo_full = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) step();
        checks++;
        if ({mem_cs, mem_we, fifo_write, host_ack, frame_done} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_flags: got cs/we/wr/ack/done=%b want 00001", {mem_cs, mem_we, fifo_write, host_ack, frame_done});
        end
        checks++;
        if ({mem_addr, mem_wdata, fifo_data, host_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: got addr=%h wdata=%h fdata=%h rdata=%h want all 0", mem_addr, mem_wdata, fifo_data, host_rdata);
        end
        rst = 1'b0;
        clear_mon();
        repeat (8) step();
        checks++;
        if (n_cs != 0 || n_wr != 0) begin
            errors++;
            $display("FAIL reset_no_fetch: got %0d mem cycles %0d writes want 0 0", n_cs, n_wr);
        end
    endtask

    task automatic test_stream();
        bit ok;
        step();
        pulse_vtrig();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL stream_done_clear: got %b want 0", frame_done);
        end
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL stream_timeout: got no frame_done want frame_done within 400 cycles");
        end
        check_frame("stream");
        checks++;
        if (rd_cyc.size() == 0 || pix_cyc.size() == 0 || pix_cyc[0] - rd_cyc[0] != 2) begin
            errors++;
            $display("FAIL stream_latency: got %0d cycles want 2", (rd_cyc.size() && pix_cyc.size()) ? pix_cyc[0] - rd_cyc[0] : -1);
        end
        checks++;
        if (pix_cyc.size() != WORDS || done_cyc != pix_cyc[WORDS-1] + 1) begin
            errors++;
            $display("FAIL stream_done_timing: got rise at %0d want one cycle after last write", done_cyc);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int snap;
        step();
        pulse_vtrig();
        for (int i = 0; i < 100 && n_wr < 5; i++) step();
        set_full(1'b1);
        snap = n_wr;
        repeat (20) step();
        checks++;
        if (n_wr != snap || n_wr_full != 0) begin
            errors++;
            $display("FAIL bp_write_while_full: got %0d writes during full (%0d flagged) want 0", n_wr - snap, n_wr_full);
        end
        checks++;
        if (n_rd - n_wr != 2) begin
            errors++;
            $display("FAIL bp_outstanding_hold: got %0d want 2", n_rd - n_wr);
        end
        set_full(1'b0);
        wait_done(ok);
        checks++;
        if (!ok || max_out > 2) begin
            errors++;
            $display("FAIL bp_max_outstanding: got %0d (done=%0b) want <=2 and done", max_out, ok);
        end
        check_frame("bp");
    endtask

    task automatic test_host();
        bit ok;
        bit found = 1'b0;
        int vga_cnt = 0;
        step();
        pulse_vtrig();
        step();
        host_req = 1'b1; host_we = 1'b1; host_addr = 12'h100; host_wdata = 16'hBEEF;
        for (int i = 0; i < 60; i++) begin
            step();
            if (mem_cs && mem_we) begin
                found = 1'b1;
                break;
            end
            if (mem_cs) vga_cnt++;
        end
        checks++;
        if (!found || vga_cnt > BURST) begin
            errors++;
            $display("FAIL host_grant: got found=%0b after %0d vga reads want grant within %0d", found, vga_cnt, BURST);
        end
        checks++;
        if (mem_addr !== 12'h100 || mem_wdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL host_write_bus: got addr=%h data=%h want 100 beef", mem_addr, mem_wdata);
        end
        step();
        checks++;
        if (host_ack !== 1'b1) begin
            errors++;
            $display("FAIL host_write_ack: got %b want 1", host_ack);
        end
        host_req = 1'b0;
        step();
        checks++;
        if (host_ack !== 1'b0) begin
            errors++;
            $display("FAIL host_ack_pulse: got %b want 0", host_ack);
        end
        host_req = 1'b1; host_we = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (mem_cs && !mem_we && mem_addr == 12'h100) begin
                found = 1'b1;
                break;
            end
        end
        step();
        checks++;
        if (!found || host_ack !== 1'b1 || host_rdata !== 16'hBEEF) begin
            errors++;
            $display("FAIL host_readback: got found=%0b ack=%b data=%h want 1 1 beef", found, host_ack, host_rdata);
        end
        host_req = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || n_host_wr != 1) begin
            errors++;
            $display("FAIL host_write_once: got %0d host writes (done=%0b) want 1", n_host_wr, ok);
        end
        check_frame("host");
    endtask

    task automatic test_flush();
        bit ok;
        set_full(1'b1);
        step();
        pulse_vtrig();
        repeat (10) step();
        checks++;
        if (n_rd != 2 || n_wr != 0) begin
            errors++;
            $display("FAIL flush_fill: got %0d reads %0d writes want 2 0", n_rd, n_wr);
        end
        pulse_vtrig();
        set_full(1'b0);
        wait_done(ok);
        checks++;
        if (!ok || rd_q.size() == 0 || rd_q[0] != BASE) begin
            errors++;
            $display("FAIL flush_full_restart: got first addr %h done=%0b want %h", rd_q.size() ? rd_q[0] : -1, ok, BASE);
        end
        check_frame("flush_full");
        step();
        pulse_vtrig();
        found_inflight: for (int i = 0; i < 100; i++) begin
            step();
            if (n_rd >= 6 && mem_cs && !mem_we) break;
        end
        pulse_vtrig();
        wait_done(ok);
        checks++;
        if (!ok || rd_q.size() == 0 || rd_q[0] != BASE) begin
            errors++;
            $display("FAIL flush_inflight_restart: got first addr %h done=%0b want %h", rd_q.size() ? rd_q[0] : -1, ok, BASE);
        end
        check_frame("flush_inflight");
    endtask

    task automatic test_reset_mid_host();
        bit found = 1'b0;
        step();
        clear_mon();
        host_req = 1'b1; host_we = 1'b0; host_addr = 12'h100;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mem_cs) begin
                found = 1'b1;
                break;
            end
        end
        rst = 1'b1;
        host_req = 1'b0;
        step();
        checks++;
        if (!found || host_ack !== 1'b0 || mem_cs !== 1'b0) begin
            errors++;
            $display("FAIL rst_host_abandon: got issued=%0b ack=%b cs=%b want 1 0 0", found, host_ack, mem_cs);
        end
        step();
        rst = 1'b0;
        checks++;
        if (n_ack != 0) begin
            errors++;
            $display("FAIL rst_no_ack: got %0d acks want 0", n_ack);
        end
        clear_mon();
        repeat (10) step();
        checks++;
        if (n_cs != 0 || frame_done !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle_after: got %0d mem cycles done=%b want 0 1", n_cs, frame_done);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_stream();
        test_backpressure();
        test_host();
        test_flush();
        test_reset_mid_host();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
